lcd_hex_frame_driver: RTL and testbench
=======================================

Name: lcd_hex_frame_driver

Overview:
- Self-contained HD44780 16x2 character-LCD driver in 8-bit write-only mode.
- Renders a parametrised packed bus of 1..32 nibbles as hex or BCD characters across both LCD lines.
- Runs its own power-up, init and frame-refresh sequencing.
- Board top level instantiates it directly from the 50 MHz clock. It is the generalised successor of the fixed six-digit display path.

Parameters:
NUM_DIGITS, 6, nibbles displayed; legal 1..32; any other value is an elaboration error.
CLKS_PER_US, 50, clock cycles per microsecond.
POWERUP_US, 15000, wait after reset before the first command.
CMD_WAIT_US, 40, execution wait after every command or character except clear.
CLR_WAIT_US, 1640, execution wait after the clear command (0x01).
SETUP_CYC, 4, cycles RS/DATA are stable before EN rises, and held after EN falls.
EN_CYC, 12, cycles EN is high per write.
AUTO_REFRESH, 1, 1 = back-to-back frames; 0 = a frame only per refresh request.

Ports:
CLOCK_50  in  1  system clock
RST  in  1  synchronous reset, active-high
iDIGITS  in  4*NUM_DIGITS  packed nibbles; MS nibble shown first
iBCD_MODE  in  1  0 = hex glyphs, 1 = BCD glyphs
iREFRESH  in  1  single-cycle frame request (used when AUTO_REFRESH=0)
oREADY  out  1  init sequence complete
oFRAME_DONE  out  1  one-cycle pulse at end of each frame
LCD_DATA  out  8  LCD data bus; the top level drives the inout pin from it
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  LCD enable strobe
LCD_RS  out  1  0 = command, 1 = data

Behaviour:
Reset:
- RST sampled high forces state S_PWR and clears all counters and the pending flag.
- Outputs: LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, oREADY=0, oFRAME_DONE=0, all from the next edge.
- Applies mid-write too: EN drops at once and no partial write completes.

Write sub-FSM (one byte):
- W_SETUP: SETUP_CYC cycles, RS/DATA driven, EN=0.
- W_PULSE: EN_CYC cycles, EN=1.
- W_HOLD: SETUP_CYC cycles, EN=0, RS/DATA held.
- W_WAIT: CMD_WAIT_US*CLKS_PER_US cycles, or CLR_WAIT_US*CLKS_PER_US after 0x01.
- Then returns done to the main FSM.

Main FSM:
- S_PWR: wait POWERUP_US*CLKS_PER_US cycles, then S_INIT.
- S_INIT: write commands 0x38, 0x0C, 0x01, 0x06 in order (RS=0). Then oREADY=1 (held until reset) and go to S_IDLE.
- S_IDLE: enter S_ADDR1 immediately if AUTO_REFRESH=1, or if AUTO_REFRESH=0 and a request is pending.
- S_ADDR1: snapshot iDIGITS and iBCD_MODE in the entry cycle, clear the pending flag, write 0x80.
- S_LINE1: 16 data writes, positions k=0..15.
- S_ADDR2: write 0xC0.
- S_LINE2: 16 data writes, positions k=16..31.
- S_DONE: oFRAME_DONE=1 for one cycle, then S_IDLE.

Glyph for position k:
- k >= NUM_DIGITS -> 0x20.
- Otherwise n = snapshot[4*(NUM_DIGITS-1-k) +: 4].
- Hex mode: n<=9 -> 0x30+n; n>=10 -> 0x37+n ('A'..'F').
- BCD mode: n<=9 -> 0x30+n; n>=10 -> 0x2D ('-').

Refresh requests:
- iREFRESH sets a one-deep pending flag, including during a frame.
- Multiple requests during a frame collapse into one extra frame.
- iREFRESH is ignored while oREADY=0.

Boundaries:
- Input changes after the snapshot do not affect the current frame (no tearing).
- A request asserted in the same cycle as the S_ADDR1 snapshot is consumed by that frame.

Optional Feature:
LCD_LEADING_ZERO_BLANK_EN
- Defined: zero nibbles before the first nonzero nibble of the snapshot render as 0x20. The last digit position (k=NUM_DIGITS-1) is always rendered.
- The blanking decision is made from the snapshot only.
- Undefined: every digit is rendered; no blanking logic is synthesised.

Test Plan:
Common bench setup: CLKS_PER_US=2, POWERUP_US=10, CMD_WAIT_US=3, CLR_WAIT_US=6.
1. Init after reset -> no EN before 20 cycles. Bytes 0x38, 0x0C, 0x01, 0x06 with RS=0. Each EN high exactly 12 cycles. Gap after 0x01 is 12 wait cycles, others 6. oREADY rises after 0x06.
2. NUM_DIGITS=6, iDIGITS=24'h12AB09, hex -> 0x80, then '1','2','A','B','0','9' + 10x 0x20, then 0xC0 + 16x 0x20, then one oFRAME_DONE pulse.
3. Same data with iBCD_MODE=1 -> '1','2','-','-','0','9'. iDIGITS changed mid-frame -> current frame unchanged; next frame shows the new value.
4. AUTO_REFRESH=0: three iREFRESH pulses during one frame -> exactly one further frame, then idle with no EN activity.
5. RST asserted during a W_PULSE of S_LINE2 -> EN=0 and all outputs reset next edge, oREADY=0. Full init sequence replays.
6. With LCD_LEADING_ZERO_BLANK_EN: 24'h000305 -> ' ',' ',' ','3','0','5'; 24'h000000 -> five 0x20 then '0'.

Source files
------------

// File: rtl/lcd_hex_frame_driver.sv
// HD44780 16x2 character-LCD driver (8-bit, write-only) rendering packed nibbles as hex/BCD glyphs.
// Optional macro LCD_LEADING_ZERO_BLANK_EN blanks leading zero digits of each frame snapshot.
module lcd_hex_frame_driver #(
  parameter int NUM_DIGITS   = 6,
  parameter int CLKS_PER_US  = 50,
  parameter int POWERUP_US   = 15000,
  parameter int CMD_WAIT_US  = 40,
  parameter int CLR_WAIT_US  = 1640,
  parameter int SETUP_CYC    = 4,
  parameter int EN_CYC       = 12,
  parameter int AUTO_REFRESH = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] iDIGITS,
  input  logic                    iBCD_MODE,
  input  logic                    iREFRESH,
  output logic                    oREADY,
  output logic                    oFRAME_DONE,
  output logic [7:0]              LCD_DATA,
  output logic                    LCD_RW,
  output logic                    LCD_EN,
  output logic                    LCD_RS
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 32) begin : g_bad_num_digits
    $error("lcd_hex_frame_driver: NUM_DIGITS must be in 1..32");
  end

  localparam logic [31:0] PWR_LAST   = 32'(POWERUP_US * CLKS_PER_US - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYC - 1);
  localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_US * CLKS_PER_US - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT_US * CLKS_PER_US - 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_DONE} state_e;
  typedef enum logic [2:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD, W_WAIT} wph_e;

  state_e                  state_q, state_d;
  wph_e                    wph_q, wph_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [7:0]              data_q, data_d;
  logic                    rs_q, rs_d;
  logic                    en_q, en_d;
  logic                    ready_q, ready_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    bcd_q, bcd_d;
  logic                    issue, wr_done;
  logic [7:0]              ibyte;
  logic                    irs;

  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h38;
      4'd1:    return 8'h0C;
      4'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] glyph(input logic [4:0] k, input logic [4*NUM_DIGITS-1:0] s,
                                       input logic bcd);
    logic [3:0] n;
    logic [7:0] g;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    logic       lead;
`endif
    g = 8'h20;
    n = 4'h0;
    if (int'(k) < NUM_DIGITS) begin
      n = s[4*(NUM_DIGITS-1-int'(k)) +: 4];
      if (n <= 4'd9)  g = 8'h30 + {4'h0, n};
      else if (bcd)   g = 8'h2D;
      else            g = 8'h37 + {4'h0, n};
`ifdef LCD_LEADING_ZERO_BLANK_EN
      // Blank only while every nibble up to k is zero; the last digit always shows.
      if (int'(k) < NUM_DIGITS-1) begin
        lead = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++)
          if (j <= int'(k) && s[4*(NUM_DIGITS-1-j) +: 4] != 4'h0) lead = 1'b0;
        if (lead) g = 8'h20;
      end
`endif
    end
    return g;
  endfunction

  always_comb begin
    state_d = state_q;
    wph_d   = wph_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    ready_d = ready_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    bcd_d   = bcd_q;
    issue   = 1'b0;
    wr_done = 1'b0;
    ibyte   = 8'h00;
    irs     = 1'b0;

    case (wph_q)
      W_SETUP: if (cnt_q == 32'd0) begin wph_d = W_PULSE; cnt_d = EN_LAST; end
               else cnt_d = cnt_q - 32'd1;
      W_PULSE: if (cnt_q == 32'd0) begin wph_d = W_HOLD; cnt_d = SETUP_LAST; end
               else cnt_d = cnt_q - 32'd1;
      W_HOLD:  if (cnt_q == 32'd0) begin
                 wph_d = W_WAIT;
                 cnt_d = (data_q == 8'h01 && !rs_q) ? CLR_LAST : CMD_LAST;
               end else cnt_d = cnt_q - 32'd1;
      W_WAIT:  if (cnt_q == 32'd0) begin wph_d = W_IDLE; wr_done = 1'b1; end
               else cnt_d = cnt_q - 32'd1;
      default: ;
    endcase

    // Next byte is issued in the same cycle the previous write finishes.
    case (state_q)
      S_PWR:   if (cnt_q == PWR_LAST) begin
                 state_d = S_INIT; idx_d = 4'd0; issue = 1'b1; ibyte = init_cmd(4'd0);
               end else cnt_d = cnt_q + 32'd1;
      S_INIT:  if (wr_done) begin
                 if (idx_q == 4'd3) begin ready_d = 1'b1; state_d = S_IDLE; end
                 else begin idx_d = idx_q + 4'd1; issue = 1'b1; ibyte = init_cmd(idx_q + 4'd1); end
               end
      S_IDLE:  if (AUTO_REFRESH != 0 || pend_q) state_d = S_ADDR1;
      S_ADDR1: if (wph_q == W_IDLE) begin
                 snap_d = iDIGITS; bcd_d = iBCD_MODE; issue = 1'b1; ibyte = 8'h80;
               end else if (wr_done) begin
                 state_d = S_LINE1; idx_d = 4'd0; issue = 1'b1; irs = 1'b1;
                 ibyte = glyph(5'd0, snap_q, bcd_q);
               end
      S_LINE1: if (wr_done) begin
                 issue = 1'b1;
                 if (idx_q == 4'd15) begin state_d = S_ADDR2; ibyte = 8'hC0; end
                 else begin
                   idx_d = idx_q + 4'd1; irs = 1'b1;
                   ibyte = glyph({1'b0, idx_q + 4'd1}, snap_q, bcd_q);
                 end
               end
      S_ADDR2: if (wr_done) begin
                 state_d = S_LINE2; idx_d = 4'd0; issue = 1'b1; irs = 1'b1;
                 ibyte = glyph(5'd16, snap_q, bcd_q);
               end
      S_LINE2: if (wr_done) begin
                 if (idx_q == 4'd15) state_d = S_DONE;
                 else begin
                   idx_d = idx_q + 4'd1; issue = 1'b1; irs = 1'b1;
                   ibyte = glyph({1'b1, idx_q + 4'd1}, snap_q, bcd_q);
                 end
               end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_PWR;
    endcase

    if (issue) begin
      wph_d  = W_SETUP;
      cnt_d  = SETUP_LAST;
      data_d = ibyte;
      rs_d   = irs;
    end

    // A request in the snapshot cycle is absorbed by the frame being started.
    if (state_q == S_ADDR1 && wph_q == W_IDLE) pend_d = 1'b0;
    else if (iREFRESH && ready_q)              pend_d = 1'b1;

    en_d = (wph_d == W_PULSE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= S_PWR;
      wph_q   <= W_IDLE;
      cnt_q   <= 32'd0;
      idx_q   <= 4'd0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wph_q   <= wph_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    snap_q <= snap_d;
    bcd_q  <= bcd_d;
  end

  assign oREADY      = ready_q;
  assign oFRAME_DONE = (state_q == S_DONE);
  assign LCD_DATA    = data_q;
  assign LCD_RW      = 1'b0;
  assign LCD_EN      = en_q;
  assign LCD_RS      = rs_q;

endmodule

// File: tb/tb_lcd_hex_frame_driver.sv
// Directed bench: dut_a free-running frames, dut_b refresh-on-request; both with shortened timing.
module tb_lcd_hex_frame_driver;

  localparam int LIMIT = 3000;

  logic        clk;
  logic        rst_a, rst_b;
  logic [23:0] dig_a, dig_b;
  logic        bcd_a, bcd_b, ref_a, ref_b;
  logic        rdy_a, rdy_b, fd_a, fd_b;
  logic [7:0]  data_a, data_b;
  logic        rw_a, rw_b, en_a, en_b, rs_a, rs_b;

  int checks = 0;
  int errors = 0;
  bit dead   = 1'b0;
  logic en_b_prev = 1'b0;
  int   rises_b   = 0;

  lcd_hex_frame_driver #(.NUM_DIGITS(6), .CLKS_PER_US(2), .POWERUP_US(10), .CMD_WAIT_US(3),
    .CLR_WAIT_US(6), .SETUP_CYC(4), .EN_CYC(12), .AUTO_REFRESH(1)) dut_a (
    .CLOCK_50(clk), .RST(rst_a), .iDIGITS(dig_a), .iBCD_MODE(bcd_a), .iREFRESH(ref_a),
    .oREADY(rdy_a), .oFRAME_DONE(fd_a), .LCD_DATA(data_a), .LCD_RW(rw_a), .LCD_EN(en_a),
    .LCD_RS(rs_a));

  lcd_hex_frame_driver #(.NUM_DIGITS(6), .CLKS_PER_US(2), .POWERUP_US(10), .CMD_WAIT_US(3),
    .CLR_WAIT_US(6), .SETUP_CYC(4), .EN_CYC(12), .AUTO_REFRESH(0)) dut_b (
    .CLOCK_50(clk), .RST(rst_b), .iDIGITS(dig_b), .iBCD_MODE(bcd_b), .iREFRESH(ref_b),
    .oREADY(rdy_b), .oFRAME_DONE(fd_b), .LCD_DATA(data_b), .LCD_RW(rw_b), .LCD_EN(en_b),
    .LCD_RS(rs_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    en_b_prev <= en_b;
    if (en_b === 1'b1 && en_b_prev === 1'b0) rises_b <= rises_b + 1;
  end

  function automatic logic en_of(input bit b);    return b ? en_b : en_a;    endfunction
  function automatic logic rs_of(input bit b);    return b ? rs_b : rs_a;    endfunction
  function automatic logic [7:0] dat_of(input bit b); return b ? data_b : data_a; endfunction
  function automatic logic rdy_of(input bit b);   return b ? rdy_b : rdy_a;  endfunction
  function automatic logic fd_of(input bit b);    return b ? fd_b : fd_a;    endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input bit b, output logic [7:0] d, output logic rs, output int hi,
                         output int lo);
    d = 8'h00; rs = 1'b0; hi = 0; lo = 0;
    if (dead) return;
    do begin
      @(negedge clk);
      if (en_of(b) === 1'b1) break;
      lo++;
    end while (lo < LIMIT);
    if (lo >= LIMIT) begin dead = 1'b1; chk("en_rise_timeout", 32'd1, 32'd0); return; end
    d  = dat_of(b);
    rs = rs_of(b);
    hi = 1;
    do begin
      @(negedge clk);
      if (en_of(b) !== 1'b1) break;
      hi++;
    end while (hi < LIMIT);
    if (hi >= LIMIT) begin dead = 1'b1; chk("en_fall_timeout", 32'd1, 32'd0); end
  endtask

  task automatic check_init(input bit b, input string tag);
    logic [7:0]  d;
    logic        rs;
    int          hi, lo, n;
    logic [31:0] cmds;
    cmds = 32'h380C0106;
    for (int i = 0; i < 4; i++) begin
      capture(b, d, rs, hi, lo);
      if (i == 0) chk($sformatf("%s pwr_wait", tag), 32'(lo >= 20), 32'd1);
      else        chk($sformatf("%s gap%0d", tag, i), 32'(lo + 1), (i == 3) ? 32'd20 : 32'd14);
      chk($sformatf("%s cmd%0d", tag, i), 32'({rs, d}), 32'({1'b0, cmds[31-8*i -: 8]}));
      chk($sformatf("%s en_width%0d", tag, i), 32'(hi), 32'd12);
    end
    chk($sformatf("%s ready_early", tag), 32'(rdy_of(b)), 32'd0);
    n = 0;
    while (rdy_of(b) !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk($sformatf("%s ready", tag), 32'(rdy_of(b)), 32'd1);
  endtask

  task automatic check_frame(input bit b, input logic [127:0] l1, input string tag,
                             input int chg_k, input logic [23:0] nd, input logic nb,
                             input int pulses);
    logic [7:0] d;
    logic       rs;
    int         hi, lo, n;
    capture(b, d, rs, hi, lo);
    chk($sformatf("%s addr1", tag), 32'({rs, d}), 32'h080);
    for (int k = 0; k < 16; k++) begin
      capture(b, d, rs, hi, lo);
      chk($sformatf("%s c%0d", tag, k), 32'({rs, d}), 32'({1'b1, l1[127-8*k -: 8]}));
      if (k == chg_k) begin
        if (b) begin dig_b = nd; bcd_b = nb; end
        else   begin dig_a = nd; bcd_a = nb; end
        for (int p = 0; p < pulses; p++) begin
          ref_b = 1'b1; @(negedge clk);
          ref_b = 1'b0; @(negedge clk);
        end
      end
    end
    capture(b, d, rs, hi, lo);
    chk($sformatf("%s addr2", tag), 32'({rs, d}), 32'h0C0);
    for (int k = 16; k < 32; k++) begin
      capture(b, d, rs, hi, lo);
      chk($sformatf("%s c%0d", tag, k), 32'({rs, d}), 32'h120);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (fd_of(b) !== 1'b1 && n < 40);
    chk($sformatf("%s frame_done", tag), 32'(fd_of(b)), 32'd1);
    @(negedge clk);
    chk($sformatf("%s frame_done_width", tag), 32'(fd_of(b)), 32'd0);
  endtask

  initial begin
    logic [127:0] l4, l5;
    logic [7:0]   d;
    logic         rs;
    int           hi, lo, n;
`ifdef LCD_LEADING_ZERO_BLANK_EN
    l4 = "   305          ";
    l5 = "     0          ";
`else
    l4 = "000305          ";
    l5 = "000000          ";
`endif
    rst_a = 1'b1; rst_b = 1'b1; ref_a = 1'b0; ref_b = 1'b0;
    dig_a = 24'h12AB09; bcd_a = 1'b0;
    dig_b = 24'hFEDC10; bcd_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst en",    32'(en_a),   32'd0);
    chk("rst rs",    32'(rs_a),   32'd0);
    chk("rst rw",    32'(rw_a),   32'd0);
    chk("rst data",  32'(data_a), 32'd0);
    chk("rst ready", 32'(rdy_a),  32'd0);
    chk("rst fd",    32'(fd_a),   32'd0);

    // dut_b gets a request while not ready; it must be dropped.
    rst_b = 1'b0;
    @(negedge clk);
    ref_b = 1'b1;
    @(negedge clk);
    ref_b = 1'b0;
    rst_a = 1'b0;

    check_init(1'b0, "initA");
    check_frame(1'b0, "12AB09          ", "f1", 3, 24'h12AB09, 1'b1, 0);
    check_frame(1'b0, "12--09          ", "f2", 3, 24'h987654, 1'b1, 0);
    check_frame(1'b0, "987654          ", "f3", 3, 24'h000305, 1'b1, 0);
    check_frame(1'b0, l4, "f4", 3, 24'h000000, 1'b1, 0);
    check_frame(1'b0, l5, "f5", -1, 24'h000000, 1'b1, 0);

    // Reset in the middle of an EN pulse of a line-2 character.
    repeat (20) capture(1'b0, d, rs, hi, lo);
    n = 0;
    while (en_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("pulse_pre_rst en", 32'(en_a), 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    chk("midrst en",    32'(en_a),   32'd0);
    chk("midrst rs",    32'(rs_a),   32'd0);
    chk("midrst data",  32'(data_a), 32'd0);
    chk("midrst ready", 32'(rdy_a),  32'd0);
    chk("midrst fd",    32'(fd_a),   32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    check_init(1'b0, "initA2");

    chk("b init_writes", 32'(rises_b), 32'd4);
    chk("b ready", 32'(rdy_b), 32'd1);
    repeat (100) @(negedge clk);
    chk("b idle_no_request", 32'(rises_b), 32'd4);
    ref_b = 1'b1;
    @(negedge clk);
    ref_b = 1'b0;
    check_frame(1'b1, "FEDC10          ", "b1", 5, 24'hFEDC10, 1'b0, 3);
    check_frame(1'b1, "FEDC10          ", "b2", -1, 24'hFEDC10, 1'b0, 0);
    repeat (300) @(negedge clk);
    chk("b idle_after_collapse", 32'(rises_b), 32'd72);
    chk("b fd_idle", 32'(fd_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
